pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_rvalid  input  1  read data valid; in order; latency 1 or more cycles.
REQ-007 imem_rdata  input  32  fetched instruction.
REQ-008 dec_instr  output  32  imem_rdata passed through to the next-PC predictor.
REQ-009 dec_pc  output  32  address of the outstanding fetch, to the predictor.
REQ-010 pred_pc  input  32  predicted next PC, combinational from dec_instr/dec_pc.
REQ-011 ex_redirect  input  1  mispredict/redirect strobe from execute.
REQ-012 ex_target  input  32  corrected PC, used when ex_redirect=1.
REQ-013 if_valid  output  1  buffer head holds a valid instruction.
REQ-014 if_instr  output  32  head instruction.
REQ-015 if_pc  output  32  head PC.
REQ-016 id_ready  input  1  decode accepts head this cycle.

Function
REQ-017 States: REQ (may issue), WAIT (one fetch outstanding), DROP (outstanding fetch to be discarded); at most one fetch is outstanding.
REQ-018 Buffer: 2-entry FIFO of {instr, pc}; if_valid = (count != 0); head is the oldest entry.
REQ-019 In REQ: imem_req=1 iff count<2 and ex_redirect=0; imem_addr=pc; issue captures dec_pc<=pc; state->WAIT.
REQ-020 In WAIT with imem_rvalid=1 and no redirect: push {imem_rdata, dec_pc}; pc<=next PC (REQ-033/034); state->REQ.
REQ-021 Response is pushed in the cycle imem_rvalid is high; the next request is issued at the earliest in the following cycle.
REQ-022 Pop when if_valid and id_ready; push and pop in the same cycle leave count unchanged.
REQ-023 The buffer never overflows: issue is gated so that count plus outstanding is at most 2.
REQ-024 ex_redirect has priority over push, pop and issue: buffer flushed (count<=0); pc<={ex_target[31:2],2'b00}.
REQ-025 Redirect in REQ: no request that cycle; state stays REQ.
REQ-026 Redirect in WAIT with imem_rvalid=0: state->DROP.
REQ-027 Redirect in WAIT with imem_rvalid=1: response discarded; state->REQ.
REQ-028 DROP: imem_req=0; the next imem_rvalid is discarded and state->REQ; a further redirect in DROP updates pc only.
REQ-029 imem_rvalid in REQ is ignored.
REQ-030 PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-031 While rst_n=0: pc=RESET_PC, state=REQ, count=0, dec_pc=RESET_PC, imem_req=0, if_valid=0, if_instr=0, if_pc=0.
REQ-032 Reset mid-fetch abandons the outstanding fetch; the first request is issued in the first clk edge cycle after rst_n rises.

Configuration
REQ-033 FETCH_PRED_EN defined: next PC after a response = pred_pc.
REQ-034 FETCH_PRED_EN undefined: next PC = dec_pc+4; pred_pc ignored; dec_instr/dec_pc still driven.

Verification
REQ-035 Reset with RESET_PC=0x100, latency 1, id_ready=1, no prediction -> imem_addr sequence 0x100, 0x104, 0x108; if_pc follows in the same order.
REQ-036 id_ready=0 held -> exactly 2 entries (0x0, 0x4) buffered, imem_req stays 0 afterwards; id_ready=1 -> pops 0x0 then 0x4.
REQ-037 ex_redirect with target 0x203 while WAIT at latency 3 -> stale response dropped, buffer empty, next imem_addr=0x200.
REQ-038 FETCH_PRED_EN, pred_pc=0x40 for fetch at 0x10 -> next imem_addr=0x40; without macro -> 0x14.
REQ-039 pc=0xFFFF_FFFC, no prediction -> next imem_addr=0x0000_0000.
REQ-040 rst_n dropped during WAIT, then released -> if_valid=0, first imem_addr=RESET_PC, late imem_rvalid before the request ignored.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - instruction fetch stage with 2-entry buffer; FETCH_PRED_EN selects predicted next PC
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic [31:0] pred_pc,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [1:0]  count;
    logic        head;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];

    logic        issue;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [31:0] next_pc;

`ifdef FETCH_PRED_EN
    assign next_pc = pred_pc;
    logic unused_bits;
    assign unused_bits = ^ex_target[1:0];
`else
    // Sequential fetch: the predictor input is deliberately left unconsumed.
    assign next_pc = dec_pc + 32'd4;
    logic unused_bits;
    assign unused_bits = ^{pred_pc, ex_target[1:0]};
`endif

    assign dec_instr = imem_rdata;
    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign if_instr  = fifo_instr[head];
    assign if_pc     = fifo_pc[head];
    assign wr_idx    = head ^ count[0];
    assign pop       = if_valid && id_ready && !ex_redirect;
    // Flops are held in reset anyway; gating only keeps the request low during reset.
    assign imem_req  = issue && rst_n;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, issue and push decisions; redirect suppresses issue and discards responses.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            S_REQ: begin
                issue = !ex_redirect && (count != 2'd2);
                if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push      = !ex_redirect;
                    state_nxt = S_REQ;
                end else if (ex_redirect) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // PC, outstanding-fetch address and instruction buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            dec_pc <= RESET_PC;
            count  <= 2'd0;
            head   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= 32'h0;
                fifo_pc[i]    <= 32'h0;
            end
        end else if (ex_redirect) begin
            pc    <= {ex_target[31:2], 2'b00};
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            if (issue) begin
                dec_pc <= pc;
            end
            if (push) begin
                fifo_instr[wr_idx] <= imem_rdata;
                fifo_pc[wr_idx]    <= dec_pc;
                pc                 <= next_pc;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - scoreboard bench for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] pred_pc;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;

    logic        use_pred = 1'b0;
    logic [31:0] pred_val = 32'h0;
    logic        resp_rvalid = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    logic        junk = 1'b0;

    always #5 clk = ~clk;

    assign pred_pc     = use_pred ? pred_val : dec_pc + 32'd4;
    assign imem_rvalid = resp_rvalid | junk;
    assign imem_rdata  = junk ? 32'hBAD0_BAD0 : resp_rdata;

    pc_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .pred_pc     (pred_pc),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    logic [31:0] exp_addr[$];
    ent_t        exp_pop[$];
    pend_t       pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: in-order responses after 'lat' cycles.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        resp_rvalid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_rvalid = 1'b1;
            resp_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
    end

    // Monitor: records requests for the memory model and checks requests and pops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) begin
                n_req = n_req + 1;
                pend.push_back('{addr: imem_addr, due: cyc + lat});
                if (exp_addr.size() > 0) begin
                    check("imem_addr", imem_addr, exp_addr.pop_front());
                end
            end
            if (if_valid && id_ready && !ex_redirect && exp_pop.size() > 0) begin
                ent_t e;
                e = exp_pop.pop_front();
                check("if_pc", if_pc, e.pc);
                check("if_instr", if_instr, e.instr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ex_redirect = 1'b0;
        junk        = 1'b0;
        id_ready    = 1'b0;
        use_pred    = 1'b0;
        tick(1);
        pend.delete();
        exp_addr.delete();
        exp_pop.delete();
        tick(1);
        pend.delete();
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h100);
        n_req = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (exp_addr.size() > 0 || exp_pop.size() > 0); i++) begin
            tick(1);
        end
        if (exp_addr.size() > 0 || exp_pop.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain: %0d addrs and %0d pops still expected, required 0",
                     name, exp_addr.size(), exp_pop.size());
            exp_addr.delete();
            exp_pop.delete();
        end
    endtask

    task automatic push_pop(input logic [31:0] a);
        exp_pop.push_back('{pc: a, instr: mem_word(a)});
    endtask

    initial begin
        tick(1);

        // Sequential fetch from RESET_PC at latency 1.
        do_reset();
        lat = 1;
        id_ready = 1'b1;
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h108);
        push_pop(32'h100);
        push_pop(32'h104);
        push_pop(32'h108);
        rst_n = 1'b1;
        drain("seq");

        // Decode stalled: buffer fills to two entries then fetching stops.
        do_reset();
        lat = 1;
        ex_redirect = 1'b1;
        ex_target = 32'h0;
        rst_n = 1'b1;
        tick(1);
        ex_redirect = 1'b0;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        tick(10);
        check("full_if_valid", {31'h0, if_valid}, 32'h1);
        check("full_imem_req", {31'h0, imem_req}, 32'h0);
        check("full_n_req", n_req, 2);
        push_pop(32'h0);
        push_pop(32'h4);
        id_ready = 1'b1;
        drain("full");

        // Redirect while waiting at latency 3: stale response dropped.
        do_reset();
        lat = 3;
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h200);
        exp_addr.push_back(32'h204);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && n_req < 2; i++) begin
            tick(1);
        end
        check("redir_n_req", n_req, 2);
        ex_redirect = 1'b1;
        ex_target = 32'h203;
        tick(1);
        ex_redirect = 1'b0;
        check("redir_flush", {31'h0, if_valid}, 32'h0);
        push_pop(32'h200);
        push_pop(32'h204);
        id_ready = 1'b1;
        drain("redir");

        // Predicted next PC versus sequential next PC.
        do_reset();
        lat = 1;
        id_ready = 1'b1;
        use_pred = 1'b1;
        pred_val = 32'h40;
        ex_redirect = 1'b1;
        ex_target = 32'h10;
        rst_n = 1'b1;
        tick(1);
        ex_redirect = 1'b0;
        exp_addr.push_back(32'h10);
`ifdef FETCH_PRED_EN
        exp_addr.push_back(32'h40);
`else
        exp_addr.push_back(32'h14);
`endif
        push_pop(32'h10);
        drain("pred");
        use_pred = 1'b0;

        // PC wraps at the top of the address space.
        do_reset();
        lat = 1;
        id_ready = 1'b1;
        ex_redirect = 1'b1;
        ex_target = 32'hFFFF_FFFC;
        rst_n = 1'b1;
        tick(1);
        ex_redirect = 1'b0;
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        push_pop(32'hFFFF_FFFC);
        push_pop(32'h0);
        drain("wrap");

        // Reset during an outstanding fetch; late response in release cycle ignored.
        do_reset();
        lat = 3;
        id_ready = 1'b1;
        rst_n = 1'b1;
        tick(2);
        check("midrst_n_req", n_req, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_imem_req", {31'h0, imem_req}, 32'h0);
        check("midrst_if_valid", {31'h0, if_valid}, 32'h0);
        tick(1);
        pend.delete();
        exp_addr.delete();
        exp_pop.delete();
        tick(1);
        pend.delete();
        n_req = 0;
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        push_pop(32'h100);
        rst_n = 1'b1;
        junk = 1'b1;
        #1;
        check("midrst_release_valid", {31'h0, if_valid}, 32'h0);
        tick(1);
        junk = 1'b0;
        check("midrst_after_junk", {31'h0, if_valid}, 32'h0);
        drain("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
